// File: rtl/instr_encoder_loader_if.sv
// Request/memory-write bundle for instr_encoder_loader.
// The master side issues encode requests and observes the instruction-memory write port.
`timescale 1ns/1ps
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_type;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instructions from type code + fields and streams them into instruction memory.
// Optional ENC_RANGE_CHECK_EN adds an immediate range check and the sticky err_range output.
`timescale 1ns/1ps
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  instr_encoder_loader_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic                         load_done,
  output logic                         err_illegal,
  output logic                         err_full
`ifdef ENC_RANGE_CHECK_EN
  ,
  output logic                         err_range
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(DEPTH-1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t      state;
  logic        in_ready_q;
  logic        we_q;
  logic        last_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] enc_word;
  logic        type_illegal;
  logic        rejected;

  logic [31:0] imm;
  assign imm = bus.in_imm;

  always_comb begin
    enc_word     = '0;
    type_illegal = 1'b0;
    case (bus.in_type)
      4'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_R};
      4'd1: enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_I};
      4'd2: enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      4'd3: enc_word = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
      4'd4: enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], OP_S};
      4'd5: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], OP_SB};
      4'd6: enc_word = {imm[31:12], bus.in_rd, OP_AUIPC};
      4'd7: enc_word = {imm[31:12], bus.in_rd, OP_LUI};
      4'd8: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OP_JAL};
      default: type_illegal = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_bad;

  // Upper bits must be a pure sign extension of the field the format can hold.
  always_comb begin
    range_bad = 1'b0;
    case (bus.in_type)
      4'd1, 4'd2, 4'd3, 4'd4:
        range_bad = (imm[31:11] != '0) && (imm[31:11] != '1);
      4'd5:
        range_bad = ((imm[31:12] != '0) && (imm[31:12] != '1)) || imm[0];
      4'd6, 4'd7:
        range_bad = (imm[11:0] != '0);
      4'd8:
        range_bad = ((imm[31:20] != '0) && (imm[31:20] != '1)) || imm[0];
      default: range_bad = 1'b0;
    endcase
  end

  assign rejected = type_illegal | range_bad;
`else
  assign rejected = type_illegal;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      word_count  <= '0;
      load_done   <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
      err_range   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= ACCEPT;
            in_ready_q  <= 1'b1;
            load_done   <= 1'b0;
            word_count  <= '0;
            addr_q      <= BASE_ADDR;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
            err_range   <= 1'b0;
`endif
          end
        end
        ACCEPT: begin
          if (bus.in_valid) begin
            if (word_count == FULL_COUNT) begin
              err_full   <= 1'b1;
              state      <= DONE;
              in_ready_q <= 1'b0;
              load_done  <= 1'b1;
            end else if (rejected) begin
              if (type_illegal) err_illegal <= 1'b1;
`ifdef ENC_RANGE_CHECK_EN
              else err_range <= 1'b1;
`endif
              if (bus.in_last) begin
                state      <= DONE;
                in_ready_q <= 1'b0;
                load_done  <= 1'b1;
              end
            end else begin
              wdata_q    <= enc_word;
              last_q     <= bus.in_last;
              we_q       <= 1'b1;
              in_ready_q <= 1'b0;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          we_q       <= 1'b0;
          word_count <= word_count + CW'(1);
          // The address parks on the last slot instead of wrapping.
          if (word_count != LAST_IDX) addr_q <= addr_q + 32'd4;
          if (last_q) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            state      <= ACCEPT;
            in_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A word still in WRITE when rst arrives is dropped rather than committed.
  assign bus.mem_we    = we_q & ~rst;
  assign bus.in_ready  = in_ready_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader with a field-level RV32I encoding model.
// Build with ENC_RANGE_CHECK_EN defined to exercise the range-check variant.
`timescale 1ns/1ps
module tb_instr_encoder_loader;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 8;
  localparam int          CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] word_count;
  logic          load_done;
  logic          err_illegal;
  logic          err_full;
`ifdef ENC_RANGE_CHECK_EN
  logic          err_range;
`endif

  instr_encoder_loader_if bus();

  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .word_count(word_count),
    .load_done(load_done),
    .err_illegal(err_illegal),
`ifdef ENC_RANGE_CHECK_EN
    .err_range(err_range),
`endif
    .err_full(err_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int we_seen = 0;

  int m_count = 0;
  int m_writes = 0;
  bit m_active = 0;
  bit m_done = 0;
  bit m_ill = 0;
  bit m_full = 0;
  bit m_rng = 0;

  always @(negedge clk) if (bus.mem_we) we_seen++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Each field is extracted by shift/mask and dropped at its bit position in the word.
  function automatic logic [31:0] ref_encode(input int t, input logic [31:0] rd, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [31:0] f3,
                                             input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] regs;
    regs = ((rs1 & 31) << 15) | ((f3 & 7) << 12);
    case (t)
      0: return ((f7 & 127) << 25) | ((rs2 & 31) << 20) | regs | ((rd & 31) << 7) | 51;
      1: return ((imm & 'hFFF) << 20) | regs | ((rd & 31) << 7) | 19;
      2: return ((imm & 'hFFF) << 20) | regs | ((rd & 31) << 7) | 3;
      3: return ((imm & 'hFFF) << 20) | ((rs1 & 31) << 15) | ((rd & 31) << 7) | 103;
      4: return (((imm >> 5) & 'h7F) << 25) | ((rs2 & 31) << 20) | regs | ((imm & 'h1F) << 7) | 35;
      5: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | ((rs2 & 31) << 20) | regs
                | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 99;
      6: return (imm & 32'hFFFF_F000) | ((rd & 31) << 7) | 23;
      7: return (imm & 32'hFFFF_F000) | ((rd & 31) << 7) | 55;
      8: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                | (((imm >> 12) & 'hFF) << 12) | ((rd & 31) << 7) | 111;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_range_bad(input int t, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (t)
      1, 2, 3, 4: return (s < -2048) || (s > 2047);
      5: return (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
      6, 7: return (imm % 4096) != 0;
      8: return (s < -1048576) || (s > 1048575) || (imm[0] == 1'b1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input int t, input int rd, input int rs1, input int rs2, input int f3,
                               input int f7, input logic [31:0] imm, input bit last);
    int n;
    bit write_exp;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    @(negedge clk);
    bus.in_type   = 4'(t);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = imm;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    write_exp = 1'b0;
    exp_word  = '0;
    exp_addr  = '0;
    if (m_count == DEPTH) begin
      m_full = 1;
      m_done = 1;
    end else if (t > 8) begin
      m_ill = 1;
      if (last) m_done = 1;
`ifdef ENC_RANGE_CHECK_EN
    end else if (ref_range_bad(t, imm)) begin
      m_rng = 1;
      if (last) m_done = 1;
`endif
    end else begin
      write_exp = 1'b1;
      exp_addr  = BASE + 32'(4 * m_count);
      exp_word  = ref_encode(t, rd, rs1, rs2, f3, f7, imm);
      m_count++;
      m_writes++;
      if (last) m_done = 1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("mem_we_latency", 32'(bus.mem_we), 32'(write_exp));
    if (write_exp) begin
      checkOutput("mem_addr", bus.mem_addr, exp_addr);
      checkOutput("mem_wdata", bus.mem_wdata, exp_word);
    end
  endtask

  task automatic doReset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_active = 0; m_done = 0; m_count = 0; m_ill = 0; m_full = 0; m_rng = 0;
  endtask

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!m_active || m_done) begin
      m_active = 1; m_done = 0; m_count = 0; m_ill = 0; m_full = 0; m_rng = 0;
    end
  endtask

  task automatic checkState(input string tag);
    int slot;
    @(negedge clk);
    slot = (m_count < DEPTH) ? m_count : DEPTH - 1;
    checkOutput({tag, ".word_count"}, 32'(word_count), 32'(m_count));
    checkOutput({tag, ".load_done"}, 32'(load_done), 32'(m_done));
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_active && !m_done));
    checkOutput({tag, ".err_illegal"}, 32'(err_illegal), 32'(m_ill));
    checkOutput({tag, ".err_full"}, 32'(err_full), 32'(m_full));
`ifdef ENC_RANGE_CHECK_EN
    checkOutput({tag, ".err_range"}, 32'(err_range), 32'(m_rng));
`endif
    checkOutput({tag, ".mem_addr"}, bus.mem_addr, BASE + 32'(4 * slot));
    checkOutput({tag, ".writes"}, 32'(we_seen), 32'(m_writes));
    checkOutput({tag, ".mem_we_idle"}, 32'(bus.mem_we), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    int t;
    logic [31:0] imm;
    bus.in_valid = 1'b0; bus.in_type = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.in_last = 1'b0;

    doReset();
    checkState("reset");
    checkOutput("reset.mem_wdata", bus.mem_wdata, 32'h0);

    doStart();
    applyStimulus(1, 1, 0, 0, 0, 0, 32'd5, 1'b1);
    checkOutput("addi.word", bus.mem_wdata, 32'h0050_0093);
    checkState("addi");

    doStart();
    applyStimulus(0, 3, 1, 2, 0, 0, 32'd0, 1'b0);
    checkOutput("add.word", bus.mem_wdata, 32'h0020_81B3);
    applyStimulus(4, 0, 1, 2, 2, 0, 32'd8, 1'b0);
    checkOutput("sw.word", bus.mem_wdata, 32'h0020_A423);
    applyStimulus(5, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1'b0);
    checkOutput("beq.word", bus.mem_wdata, 32'hFE00_0EE3);
    applyStimulus(8, 1, 0, 0, 0, 0, 32'd8, 1'b0);
    checkOutput("jal.word", bus.mem_wdata, 32'h0080_00EF);
    applyStimulus(7, 5, 0, 0, 0, 0, 32'h1234_5000, 1'b1);
    checkOutput("lui.word", bus.mem_wdata, 32'h1234_52B7);
    checkState("stream");
    checkOutput("stream.count", 32'(word_count), 32'd5);

    doStart();
    applyStimulus(1, 2, 0, 0, 0, 0, 32'd1, 1'b0);
    applyStimulus(12, 2, 0, 0, 0, 0, 32'd1, 1'b0);
    checkOutput("illegal.flag", 32'(err_illegal), 32'd1);
    applyStimulus(1, 3, 0, 0, 0, 0, 32'd2, 1'b0);
    checkOutput("illegal.next_addr", bus.mem_addr, BASE + 32'd4);
    applyStimulus(1, 4, 0, 0, 0, 0, 32'd3, 1'b1);
    checkState("illegal");

    doStart();
    for (int i = 0; i <= DEPTH; i++) applyStimulus(7, i, 0, 0, 0, 0, 32'(i) << 12, 1'b0);
    checkState("full");
    checkOutput("full.flag", 32'(err_full), 32'd1);
    checkOutput("full.addr", bus.mem_addr, BASE + 32'(4 * (DEPTH - 1)));

    doStart();
    applyStimulus(1, 1, 0, 0, 0, 0, 32'd7, 1'b0);
    doStart();
    checkState("start_ignored");
    applyStimulus(1, 1, 0, 0, 0, 0, 32'd9, 1'b1);
    checkState("start_ignored_end");

    doStart();
    applyStimulus(1, 1, 0, 0, 0, 0, 32'd2048, 1'b1);
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("range.flag", 32'(err_range), 32'd1);
`else
    checkOutput("trunc.word", bus.mem_wdata, 32'h8000_0093);
`endif
    checkState("range");

    doStart();
    @(negedge clk);
    bus.in_type = 4'd1; bus.in_rd = 5'd6; bus.in_rs1 = 5'd0; bus.in_funct3 = 3'd0;
    bus.in_imm = 32'd11; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid.mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_active = 0; m_done = 0; m_count = 0; m_ill = 0; m_full = 0; m_rng = 0;
    checkOutput("rst_mid.mem_wdata", bus.mem_wdata, 32'h0);
    checkState("rst_mid");
    repeat (2) @(negedge clk);
    checkOutput("rst_mid.ready_hold", 32'(bus.in_ready), 32'd0);

    for (int s = 0; s < 20; s++) begin
      doStart();
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++) begin
        if (m_done) break;
        t = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        if ($urandom_range(0, 1) == 1) imm = $urandom;
        else imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        applyStimulus(t, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 7), $urandom_range(0, 127), imm, i == len - 1);
      end
      checkState("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
